// File: rtl/reg_bank4_pkg.sv
// Shared types and enable-pattern helpers for the 4-entry register bank.
// Classifies a decoded write-enable vector as idle, legal single write or illegal multi-hot.
package regbank_pkg;

  localparam int unsigned NUM_REGS = 4;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_SINGLE,
    WR_MULTI
  } wr_kind_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return popcount4(v) == 3'd1;
  endfunction

  function automatic logic is_multihot(input logic [3:0] v);
    return popcount4(v) >= 3'd2;
  endfunction

  function automatic wr_kind_t classify(input logic [3:0] v);
    if (is_multihot(v)) begin
      return WR_MULTI;
    end else if (is_onehot(v)) begin
      return WR_SINGLE;
    end
    return WR_NONE;
  endfunction

endpackage

// File: rtl/reg_bank4_if.sv
// Write/read bus between the write decoder, the register bank and its readers.
// The bank is the slave; whoever drives enables and read indices is the master.
interface reg_bank4_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ERR_CW = 4
);
  logic [3:0]        wr_onehot;
  logic [WIDTH-1:0]  wr_data;
  logic [1:0]        rd_addr0;
  logic [1:0]        rd_addr1;
  logic [WIDTH-1:0]  rd_data0;
  logic [WIDTH-1:0]  rd_data1;
  logic              onehot_err;
  logic [ERR_CW-1:0] err_count;

  modport master (
    output wr_onehot, wr_data, rd_addr0, rd_addr1,
    input  rd_data0, rd_data1, onehot_err, err_count
  );

  modport slave (
    input  wr_onehot, wr_data, rd_addr0, rd_addr1,
    output rd_data0, rd_data1, onehot_err, err_count
  );
endinterface

// File: rtl/reg_bank4_en_reg.sv
// One storage entry: WIDTH-bit register with load enable and async reset value.
module en_reg #(
  parameter int unsigned           WIDTH     = 64,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_bank4.sv
// 4-entry register bank fed by one-hot write enables, with two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero top entry and multi-hot error tracking.
module reg_bank4
  import regbank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      BYPASS    = 1,
  parameter int unsigned      ZERO_TOP  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      ERR_CW    = 4
) (
  input logic        clk,
  input logic        reset,
  reg_bank4_if.slave bus
);

  wr_kind_t wr_kind;
  assign wr_kind = classify(bus.wr_onehot);

  logic [WIDTH-1:0] entry [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    if (ZERO_TOP != 0 && i == NUM_REGS - 1) begin : g_zero
      assign entry[i] = '0;
    end else begin : g_reg
      en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_kind == WR_SINGLE && bus.wr_onehot[i]),
        .d     (bus.wr_data),
        .q     (entry[i])
      );
    end
  end

  reg_idx_t         rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = bus.rd_addr0;
  assign rd_addr[1] = bus.rd_addr1;

  // Priority: hardwired zero beats bypass, bypass beats stored contents.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = entry[rd_addr[p]];
      if (BYPASS != 0 && wr_kind == WR_SINGLE && bus.wr_onehot[rd_addr[p]]) begin
        rd_data[p] = bus.wr_data;
      end
      if (ZERO_TOP != 0 && rd_addr[p] == reg_idx_t'(NUM_REGS - 1)) begin
        rd_data[p] = '0;
      end
    end
  end

  assign bus.rd_data0 = rd_data[0];
  assign bus.rd_data1 = rd_data[1];

  logic              onehot_err_d;
  logic              onehot_err_q;
  logic [ERR_CW-1:0] err_count_d;
  logic [ERR_CW-1:0] err_count_q;

  always_comb begin
    onehot_err_d = (wr_kind == WR_MULTI);
    err_count_d  = err_count_q;
    if (onehot_err_d && err_count_q != '1) begin
      err_count_d = err_count_q + ERR_CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      onehot_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      onehot_err_q <= onehot_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.onehot_err = onehot_err_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_reg_bank4.sv
// Drives two bank configurations (bypass+zero-top, plain) with identical stimulus and
// checks both against an array-based reference model of the bank's rules.
module tb_reg_bank4;

  localparam logic [63:0] RV_A = 64'h0;
  localparam logic [63:0] RV_B = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  wr_onehot = 4'b0000;
  logic [63:0] wr_data = '0;
  logic [1:0]  a0 = 2'd0;
  logic [1:0]  a1 = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem_a [4];
  logic [63:0] mem_b [4];
  logic        err_exp;
  int          cnt_exp;

  reg_bank4_if #(.WIDTH(64), .ERR_CW(4)) if_a ();
  reg_bank4_if #(.WIDTH(64), .ERR_CW(4)) if_b ();

  assign if_a.wr_onehot = wr_onehot;
  assign if_a.wr_data   = wr_data;
  assign if_a.rd_addr0  = a0;
  assign if_a.rd_addr1  = a1;
  assign if_b.wr_onehot = wr_onehot;
  assign if_b.wr_data   = wr_data;
  assign if_b.rd_addr0  = a0;
  assign if_b.rd_addr1  = a1;

  reg_bank4 #(
    .WIDTH(64), .BYPASS(1), .ZERO_TOP(1), .RESET_VAL(RV_A), .ERR_CW(4)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );

  reg_bank4 #(
    .WIDTH(64), .BYPASS(0), .ZERO_TOP(0), .RESET_VAL(RV_B), .ERR_CW(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input bit is_a, input logic [1:0] addr);
    if (is_a && addr == 2'd3) return 64'h0;
    if (is_a && $countones(wr_onehot) == 1 && wr_onehot[addr]) return wr_data;
    return is_a ? mem_a[addr] : mem_b[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = RV_A;
      mem_b[i] = RV_B;
    end
    err_exp = 1'b0;
    cnt_exp = 0;
  endtask

  task automatic model_edge();
    int n;
    n = $countones(wr_onehot);
    err_exp = (n >= 2);
    if (n >= 2 && cnt_exp < 15) cnt_exp++;
    if (n == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_onehot[i]) begin
          mem_b[i] = wr_data;
          if (i != 3) mem_a[i] = wr_data;
        end
      end
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_a_rd0"}, if_a.rd_data0, exp_rd(1'b1, a0));
    check({tag, "_a_rd1"}, if_a.rd_data1, exp_rd(1'b1, a1));
    check({tag, "_b_rd0"}, if_b.rd_data0, exp_rd(1'b0, a0));
    check({tag, "_b_rd1"}, if_b.rd_data1, exp_rd(1'b0, a1));
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_a_err"}, {63'd0, if_a.onehot_err}, {63'd0, err_exp});
    check({tag, "_b_err"}, {63'd0, if_b.onehot_err}, {63'd0, err_exp});
    check({tag, "_a_cnt"}, {60'd0, if_a.err_count}, 64'(cnt_exp));
    check({tag, "_b_cnt"}, {60'd0, if_b.err_count}, 64'(cnt_exp));
  endtask

  // Inputs are applied at the negedge; reads checked before the edge, then state after it.
  task automatic cycle(input string tag);
    #1;
    check_reads({tag, "_pre"});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_reads({tag, "_post"});
    check_regs(tag);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_reads("rst_async");
    check_regs("rst_async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reads("rst_rel");
    check_regs("rst_rel");

    // Single write to entry 0: bypassed on A, visible only after the edge on B.
    @(negedge clk);
    wr_onehot = 4'b0001; wr_data = 64'hDEAD_BEEF_0000_0001; a0 = 2'd0; a1 = 2'd1;
    cycle("wr0");
    wr_onehot = 4'b0000; a1 = 2'd0;
    cycle("idle0");
    wr_onehot = 4'b0010; wr_data = 64'h1111_2222_3333_4444; a0 = 2'd1; a1 = 2'd2;
    cycle("wr1");
    wr_onehot = 4'b0100; wr_data = 64'h5555_6666_7777_8888;
    cycle("wr2");

    // Multi-hot: nothing written, one-cycle error pulse, counter saturates.
    wr_onehot = 4'b0110; wr_data = '1;
    cycle("multi1");
    wr_onehot = 4'b0000;
    cycle("multi_gap");
    for (int k = 0; k < 20; k++) begin
      wr_onehot = (k % 2 == 0) ? 4'b0110 : 4'b1111;
      wr_data = {$urandom, $urandom};
      cycle("multi_rep");
    end
    check("sat_a", {60'd0, if_a.err_count}, 64'd15);
    check("sat_b", {60'd0, if_b.err_count}, 64'd15);

    // Entry 3 write: dropped on A (no error), stored on B.
    wr_onehot = 4'b1000; wr_data = 64'd5; a0 = 2'd3; a1 = 2'd3;
    cycle("top_wr");
    wr_onehot = 4'b0000;
    cycle("top_rd");

    // Async reset in the middle of a write cycle.
    wr_onehot = 4'b0100; wr_data = 64'hCAFE_F00D_0000_0002; a0 = 2'd2; a1 = 2'd2;
    @(posedge clk);
    model_edge();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("midrst_b_rd0", if_b.rd_data0, RV_B);
    check_regs("midrst");
    wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    check("rsthold_b_rd0", if_b.rd_data0, RV_B);
    check_regs("rsthold");
    reset = 1'b0;
    wr_onehot = 4'b0000;
    cycle("post_rst");
    wr_onehot = 4'b0100; wr_data = 64'h0BAD_CAFE_1234_5678;
    cycle("resume");

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       wr_onehot = 4'b0000;
        1, 2:    wr_onehot = 4'b0001 << $urandom_range(0, 3);
        default: wr_onehot = 4'($urandom_range(1, 15));
      endcase
      wr_data = {$urandom, $urandom};
      a0 = 2'($urandom_range(0, 3));
      a1 = 2'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
